// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_N_RD   = 2;

    localparam int MAX_ADDR_W = 16;
    localparam int MAX_RD     = 4;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Extract port p's address from a packed address bus, zero-extended to MAX_ADDR_W.
    function automatic logic [MAX_ADDR_W-1:0] ra_slice(
        input logic [MAX_RD*MAX_ADDR_W-1:0] ra,
        input int unsigned                  p,
        input int unsigned                  aw
    );
        return MAX_ADDR_W'(ra >> (p * aw)) & ({MAX_ADDR_W{1'b1}} >> (MAX_ADDR_W - aw));
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: zeroes one register per cycle for DEPTH cycles after CLR.
// CLR while busy is ignored; BUSY and the clear write controls are registered.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_t         state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RF_IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    if (CLR) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RF_IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RF_IDLE;
            endcase
        end
    end

    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file, 1-cycle registered reads, bulk clear stalls reads/writes while BUSY.
// Define REGFILE_BYPASS_EN for write-first forwarding; default build is read-before-write.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int N_RD     = DEF_N_RD,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WA,
    input  logic [DATA_W-1:0]        WD,
    input  logic [N_RD-1:0]          RE,
    input  logic [N_RD*ADDR_W-1:0]   RA,
    output logic [N_RD*DATA_W-1:0]   RD,
    output logic [N_RD-1:0]          RVALID,
    input  logic                     CLR,
    output logic                     BUSY
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wa_is_zero;
    logic [MAX_RD*MAX_ADDR_W-1:0] ra_pad;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .CLK      (CLK),
        .RST      (RST),
        .CLR      (CLR),
        .BUSY     (BUSY),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign wa_is_zero = (ZERO_REG != 0) && (WA == '0);
    assign ra_pad     = {{(MAX_RD*MAX_ADDR_W - N_RD*ADDR_W){1'b0}}, RA};

    // The clear sweep owns the write port whenever it is active, so WE is dropped then.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (WE && !wa_is_zero) begin
            mem[WA] <= WD;
        end
    end

    for (genvar p = 0; p < N_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_p;
        logic [DATA_W-1:0] rd_val;
        logic [DATA_W-1:0] rd_q;
        logic              rvld_q;

        assign ra_p = ADDR_W'(ra_slice(ra_pad, p, ADDR_W));

        always_comb begin
            rd_val = mem[ra_p];
            if ((ZERO_REG != 0) && (ra_p == '0)) begin
                rd_val = '0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (WE && (ra_p == WA)) begin
                rd_val = WD;
            end
`endif
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                rd_q   <= '0;
                rvld_q <= 1'b0;
            end else if (BUSY) begin
                rvld_q <= 1'b0;
            end else if (RE[p]) begin
                rd_q   <= rd_val;
                rvld_q <= 1'b1;
            end else begin
                rvld_q <= 1'b0;
            end
        end

        assign RD[p*DATA_W +: DATA_W] = rd_q;
        assign RVALID[p]              = rvld_q;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp against an array-level reference model.
module tb_register_file_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              WE;
    logic [AW-1:0]     WA;
    logic [DW-1:0]     WD;
    logic [NRD-1:0]    RE;
    logic [NRD*AW-1:0] RA;
    logic [NRD*DW-1:0] RD;
    logic [NRD-1:0]    RVALID;
    logic              CLR;
    logic              BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [DEPTH];
    int            busy_left;
    logic [DW-1:0] exp_rd  [NRD];
    logic          exp_vld [NRD];

    register_file_mp dut (
        .CLK    (CLK),
        .RST    (RST),
        .WE     (WE),
        .WA     (WA),
        .WD     (WD),
        .RE     (RE),
        .RA     (RA),
        .RD     (RD),
        .RVALID (RVALID),
        .CLR    (CLR),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        WE = 1'b0; WA = '0; WD = '0; RE = '0; RA = '0; CLR = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        busy_left = 0;
        for (int p = 0; p < NRD; p++) begin
            exp_rd[p]  = '0;
            exp_vld[p] = 1'b0;
        end
    endtask

    // Apply the currently driven inputs to the model, then advance one clock.
    task automatic tick();
        logic [AW-1:0] a;
        if (busy_left > 0) begin
            for (int p = 0; p < NRD; p++) exp_vld[p] = 1'b0;
            busy_left--;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (RE[p]) begin
                    a = RA[p*AW +: AW];
                    if (a == 0)                         exp_rd[p] = '0;
                    else if (BYP && WE && WA == a)      exp_rd[p] = WD;
                    else                                exp_rd[p] = model[a];
                    exp_vld[p] = 1'b1;
                end else begin
                    exp_vld[p] = 1'b0;
                end
            end
            if (WE && WA != 0) model[WA] = WD;
            if (CLR) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) model[i] = '0;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        model_reset();
        #3;
        n_tests++;
        if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", BUSY); end
        n_tests++;
        if (RVALID !== '0) begin n_fail++; $display("FAIL reset_rvalid got=%b want=0", RVALID); end
        n_tests++;
        if (RD !== '0) begin n_fail++; $display("FAIL reset_rd got=%h want=0", RD); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            RE = 2'b11;
            RA = {AW'(DEPTH - 1 - i), AW'(i)};
            tick();
            for (int p = 0; p < NRD; p++) begin
                n_tests++;
                if (RD[p*DW +: DW] !== '0 || RVALID[p] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL reset_readall i=%0d port=%0d rd=%h vld=%0b want rd=0 vld=1",
                             i, p, RD[p*DW +: DW], RVALID[p]);
                end
            end
        end
        idle_inputs();
        tick();
        n_tests++;
        if (RVALID !== '0) begin n_fail++; $display("FAIL rvalid_drop got=%b want=0", RVALID); end
    endtask

    task automatic test_write_read();
        idle_inputs();
        WE = 1'b1; WA = 5'd5; WD = 32'hDEADBEEF;
        tick();
        idle_inputs();
        RE = 2'b11; RA = {5'd5, 5'd5};
        tick();
        for (int p = 0; p < NRD; p++) begin
            n_tests++;
            if (RD[p*DW +: DW] !== 32'hDEADBEEF || RVALID[p] !== 1'b1) begin
                n_fail++;
                $display("FAIL write_read port=%0d rd=%h vld=%0b want rd=deadbeef vld=1",
                         p, RD[p*DW +: DW], RVALID[p]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        idle_inputs();
        WE = 1'b1; WA = 5'd7; WD = 32'h0000AAAA;
        tick();
        WD = 32'h00001234; RE = 2'b01; RA = {5'd0, 5'd7};
        tick();
        want = BYP ? 32'h00001234 : 32'h0000AAAA;
        n_tests++;
        if (RD[DW-1:0] !== want) begin
            n_fail++; $display("FAIL same_cycle_rw got=%h want=%h", RD[DW-1:0], want);
        end
        WE = 1'b0;
        tick();
        n_tests++;
        if (RD[DW-1:0] !== 32'h00001234) begin
            n_fail++; $display("FAIL read_after_write got=%h want=00001234", RD[DW-1:0]);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF;
        tick();
        idle_inputs();
        RE = 2'b11; RA = '0;
        tick();
        n_tests++;
        if (RD !== '0 || RVALID !== 2'b11) begin
            n_fail++; $display("FAIL zero_reg rd=%h vld=%b want rd=0 vld=11", RD, RVALID);
        end
        WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; RE = 2'b01; RA = '0;
        tick();
        n_tests++;
        if (RD[DW-1:0] !== '0) begin
            n_fail++; $display("FAIL zero_reg_same_cycle got=%h want=0", RD[DW-1:0]);
        end
    endtask

    task automatic test_clear();
        logic [NRD*DW-1:0] held;
        int busy_cycles;
        int guard;
        idle_inputs();
        for (int i = 1; i < DEPTH; i++) begin
            WE = 1'b1; WA = AW'(i); WD = $urandom | 32'h1;
            tick();
        end
        idle_inputs();
        RE = 2'b11; RA = {5'd3, 5'd30};
        tick();
        held = RD;
        idle_inputs();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        n_tests++;
        if (BUSY !== 1'b1) begin n_fail++; $display("FAIL clr_busy_start got=%0b want=1", BUSY); end
        busy_cycles = 1;
        guard = 0;
        while (BUSY === 1'b1 && guard < 4 * DEPTH) begin
            WE = 1'($urandom); WA = AW'($urandom); WD = $urandom;
            RE = NRD'($urandom); RA = NRD*AW'($urandom);
            CLR = (busy_cycles == 10);
            tick();
            guard++;
            if (BUSY === 1'b1) busy_cycles++;
            n_tests++;
            if (RVALID !== '0 || RD !== held) begin
                n_fail++;
                $display("FAIL clr_ignore cyc=%0d vld=%b rd=%h want vld=0 rd=%h",
                         busy_cycles, RVALID, RD, held);
            end
        end
        n_tests++;
        if (busy_cycles != DEPTH || BUSY !== 1'b0) begin
            n_fail++; $display("FAIL clr_busy_len got=%0d want=%0d", busy_cycles, DEPTH);
        end
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            RE = 2'b11; RA = {AW'(i), AW'(DEPTH - 1 - i)};
            tick();
            n_tests++;
            if (RD !== '0 || RVALID !== 2'b11) begin
                n_fail++; $display("FAIL clr_after i=%0d rd=%h vld=%b want rd=0 vld=11", i, RD, RVALID);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        idle_inputs();
        WE = 1'b1; WA = 5'd9; WD = 32'h5555AAAA;
        tick();
        idle_inputs();
        RE = 2'b11; RA = {5'd9, 5'd9};
        tick();
        idle_inputs();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (BUSY !== 1'b0 || RD !== '0 || RVALID !== '0) begin
            n_fail++; $display("FAIL rst_mid_clear busy=%0b rd=%h vld=%b want all 0", BUSY, RD, RVALID);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            RE = 2'b11; RA = {AW'(i), AW'(i)};
            tick();
            n_tests++;
            if (RD !== '0 || RVALID !== 2'b11) begin
                n_fail++; $display("FAIL rst_mid_clear_read i=%0d rd=%h vld=%b want rd=0 vld=11", i, RD, RVALID);
            end
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 400; n++) begin
            WE  = 1'($urandom);
            WA  = ($urandom_range(1) == 0) ? AW'($urandom_range(7)) : AW'($urandom);
            WD  = $urandom;
            RE  = NRD'($urandom);
            for (int p = 0; p < NRD; p++)
                RA[p*AW +: AW] = ($urandom_range(1) == 0) ? AW'($urandom_range(7)) : AW'($urandom);
            CLR = ($urandom_range(63) == 0);
            tick();
            for (int p = 0; p < NRD; p++) begin
                n_tests++;
                if (RD[p*DW +: DW] !== exp_rd[p] || RVALID[p] !== exp_vld[p]) begin
                    n_fail++;
                    $display("FAIL random n=%0d port=%0d rd=%h vld=%0b want rd=%h vld=%0b",
                             n, p, RD[p*DW +: DW], RVALID[p], exp_rd[p], exp_vld[p]);
                end
            end
            n_tests++;
            if (BUSY !== (busy_left > 0)) begin
                n_fail++; $display("FAIL random_busy n=%0d got=%0b want=%0b", n, BUSY, busy_left > 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
